// File: rtl/reliable_send_seq_engine.sv
// Reliable-send sequence engine.
// Stamps each hit PHV with its flow's sequence number and then increments
// that number. A management port lets software write, read or clear the
// per-flow sequence table.
//
// Handshake rule for every valid/ready pair on this block:
// a transfer happens on a rising clk edge where valid && ready. A source
// holds its payload stable while valid is high and ready is low. Ready may
// depend on valid only where stated: s_mod_ready yields to s_phv_valid.
module reliable_send_seq_engine #(
  parameter int PHV_WIDTH    = 408,
  parameter int ADDR_WIDTH   = 10,
  parameter int SEQ_WIDTH    = 32,
  parameter int SEQ_OFFSET   = 0,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reliable_enable,
  input  logic [PHV_WIDTH-1:0]    s_phv_info,
  input  logic                    s_phv_hit,
  input  logic [ADDR_WIDTH-1:0]   s_phv_addr,
  input  logic                    s_phv_valid,
  output logic                    s_phv_ready,
  output logic [PHV_WIDTH-1:0]    m_phv_info,
  output logic                    m_phv_wrap,
  output logic                    m_phv_valid,
  input  logic                    m_phv_ready,
  input  logic [ADDR_WIDTH-1:0]   s_mod_addr,
  input  logic [SEQ_WIDTH-1:0]    s_mod_data,
  input  logic [OPCODE_WIDTH-1:0] s_mod_opcode,
  input  logic                    s_mod_valid,
  output logic                    s_mod_ready,
  output logic [SEQ_WIDTH-1:0]    m_mod_bdata,
  output logic                    m_mod_bvalid,
  input  logic                    m_mod_bready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [OPCODE_WIDTH-1:0] OP_WRITE = OPCODE_WIDTH'(4'b0001);
  localparam logic [OPCODE_WIDTH-1:0] OP_READ  = OPCODE_WIDTH'(4'b0010);
  localparam logic [OPCODE_WIDTH-1:0] OP_CLEAR = OPCODE_WIDTH'(4'b1101);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RESP  = 2'd2
  } fsm_t;

  fsm_t                  fsm;
  fsm_t                  fsm_next;
  logic [SEQ_WIDTH-1:0]  seq_tbl [DEPTH];
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  phv_fire;
  logic                  stamp;
  logic                  mod_fire;
  logic                  clr_last;
  logic [SEQ_WIDTH-1:0]  cur_seq;
  logic [PHV_WIDTH-1:0]  phv_stamped;

  assign s_phv_ready = (fsm == IDLE) && (!m_phv_valid || m_phv_ready);
  assign s_mod_ready = (fsm == IDLE) && !m_mod_bvalid && !s_phv_valid;
  assign phv_fire    = s_phv_valid && s_phv_ready;
  assign stamp       = phv_fire && s_phv_hit && reliable_enable;
  assign mod_fire    = s_mod_valid && s_mod_ready;
  assign clr_last    = (fsm == CLEAR) && (clr_idx == {ADDR_WIDTH{1'b1}});
  // The table is written at the same edge the stamp is taken, so the next
  // PHV to the same flow already sees the incremented value.
  assign cur_seq     = seq_tbl[s_phv_addr];

  // Replace only the sequence field; every other PHV bit passes through.
  always_comb begin
    phv_stamped = s_phv_info;
    if (s_phv_hit && reliable_enable) begin
      phv_stamped[SEQ_OFFSET +: SEQ_WIDTH] = cur_seq;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_next;
  end

  // FSM next-state: a CLEAR_ALL sweeps the whole table, then answers once.
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE:    if (mod_fire && (s_mod_opcode == OP_CLEAR)) fsm_next = CLEAR;
      CLEAR:   if (clr_last) fsm_next = RESP;
      RESP:    if (m_mod_bready) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  // Sweep index: parked at zero in IDLE, advances once per CLEAR cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                clr_idx <= '0;
    else if (fsm == CLEAR)  clr_idx <= clr_idx + 1'b1;
    else                    clr_idx <= '0;
  end

  // Flow table: sweep clear, stamp increment, or management write.
  // PHV and management acceptance never coincide, so no write conflicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) seq_tbl[i] <= '0;
    end else if (fsm == CLEAR) begin
      seq_tbl[clr_idx] <= '0;
    end else if (stamp) begin
      seq_tbl[s_phv_addr] <= cur_seq + 1'b1;
    end else if (mod_fire && (s_mod_opcode == OP_WRITE)) begin
      seq_tbl[s_mod_addr] <= s_mod_data;
    end
  end

  // PHV output register: loads on acceptance, holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phv_valid <= 1'b0;
      m_phv_info  <= '0;
      m_phv_wrap  <= 1'b0;
    end else if (phv_fire) begin
      m_phv_valid <= 1'b1;
      m_phv_info  <= phv_stamped;
      m_phv_wrap  <= stamp && (cur_seq == {SEQ_WIDTH{1'b1}});
    end else if (m_phv_ready) begin
      m_phv_valid <= 1'b0;
    end
  end

  // Management response register: one response per accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mod_bvalid <= 1'b0;
      m_mod_bdata  <= '0;
    end else if (mod_fire && (s_mod_opcode != OP_CLEAR)) begin
      m_mod_bvalid <= 1'b1;
      case (s_mod_opcode)
        OP_WRITE: m_mod_bdata <= s_mod_data;
        OP_READ:  m_mod_bdata <= seq_tbl[s_mod_addr];
        default:  m_mod_bdata <= '0;
      endcase
    end else if (clr_last) begin
      m_mod_bvalid <= 1'b1;
      m_mod_bdata  <= '0;
    end else if (m_mod_bvalid && m_mod_bready) begin
      m_mod_bvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reliable_send_seq_engine.sv
// Bench for reliable_send_seq_engine: vector table for management ops,
// directed multi-cycle sequences, then randomized traffic against a
// per-flow counter model.
module tb_reliable_send_seq_engine;

  localparam int PW  = 72;
  localparam int AW  = 4;
  localparam int SW  = 32;
  localparam int OFF = 20;
  localparam int OW  = 4;
  localparam int DEPTH = 1 << AW;

  localparam logic [3:0] OP_WRITE = 4'b0001;
  localparam logic [3:0] OP_READ  = 4'b0010;
  localparam logic [3:0] OP_CLEAR = 4'b1101;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          reliable_enable = 1'b0;
  logic [PW-1:0] s_phv_info = '0;
  logic          s_phv_hit = 1'b0;
  logic [AW-1:0] s_phv_addr = '0;
  logic          s_phv_valid = 1'b0;
  logic          s_phv_ready;
  logic [PW-1:0] m_phv_info;
  logic          m_phv_wrap;
  logic          m_phv_valid;
  logic          m_phv_ready;
  logic [AW-1:0] s_mod_addr = '0;
  logic [SW-1:0] s_mod_data = '0;
  logic [OW-1:0] s_mod_opcode = '0;
  logic          s_mod_valid = 1'b0;
  logic          s_mod_ready;
  logic [SW-1:0] m_mod_bdata;
  logic          m_mod_bvalid;
  logic          m_mod_bready = 1'b0;

  logic ready_force = 1'b1;
  logic rnd_bp      = 1'b0;
  logic rnd_val     = 1'b1;

  int tests = 0;
  int fails = 0;

  logic [SW-1:0] ref_tbl [DEPTH];
  logic [PW:0]   exp_q [$];

  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] addr;
    logic [SW-1:0] data;
    logic [SW-1:0] exp;
  } mod_vec_t;

  mod_vec_t vecs [10];

  reliable_send_seq_engine #(
    .PHV_WIDTH(PW), .ADDR_WIDTH(AW), .SEQ_WIDTH(SW),
    .SEQ_OFFSET(OFF), .OPCODE_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .reliable_enable(reliable_enable),
    .s_phv_info(s_phv_info), .s_phv_hit(s_phv_hit), .s_phv_addr(s_phv_addr),
    .s_phv_valid(s_phv_valid), .s_phv_ready(s_phv_ready),
    .m_phv_info(m_phv_info), .m_phv_wrap(m_phv_wrap),
    .m_phv_valid(m_phv_valid), .m_phv_ready(m_phv_ready),
    .s_mod_addr(s_mod_addr), .s_mod_data(s_mod_data),
    .s_mod_opcode(s_mod_opcode), .s_mod_valid(s_mod_valid),
    .s_mod_ready(s_mod_ready), .m_mod_bdata(m_mod_bdata),
    .m_mod_bvalid(m_mod_bvalid), .m_mod_bready(m_mod_bready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign m_phv_ready = rnd_bp ? rnd_val : ready_force;

  initial forever begin
    @(negedge clk);
    rnd_val = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic void model_zero();
    for (int i = 0; i < DEPTH; i++) ref_tbl[i] = '0;
  endfunction

  // Expected {wrap, phv} for an accepted PHV; advances the flow counter.
  function automatic logic [PW:0] phv_model(input logic [PW-1:0] info, input logic hit,
                                            input logic [AW-1:0] a, input logic en);
    logic [PW-1:0] mask;
    logic [PW-1:0] fld;
    logic          w;
    if (!(hit && en)) return {1'b0, info};
    mask = PW'({SW{1'b1}}) << OFF;
    fld  = PW'(ref_tbl[a]) << OFF;
    w    = (ref_tbl[a] == {SW{1'b1}});
    ref_tbl[a] = ref_tbl[a] + 1;
    return {w, (info & ~mask) | fld};
  endfunction

  // Expected response data for a management op; applies its effect.
  function automatic logic [SW-1:0] mod_model(input logic [3:0] op, input logic [AW-1:0] a,
                                              input logic [SW-1:0] d);
    case (op)
      OP_WRITE: begin ref_tbl[a] = d; return d; end
      OP_READ:  return ref_tbl[a];
      OP_CLEAR: begin model_zero(); return '0; end
      default:  return '0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_phv(input logic [PW-1:0] info, input logic hit, input logic [AW-1:0] a,
                          input logic en, output logic [PW:0] expv);
    int budget = 200;
    s_phv_info = info; s_phv_hit = hit; s_phv_addr = a; reliable_enable = en;
    s_phv_valid = 1'b1;
    expv = '0;
    #1;
    while (!s_phv_ready && budget > 0) begin
      @(negedge clk); #2; budget--;
    end
    if (budget == 0) begin
      check("phv_accept_timeout", 1'b0, 1'b1);
      s_phv_valid = 1'b0;
      return;
    end
    expv = phv_model(info, hit, a, en);
    exp_q.push_back(expv);
    step();
    s_phv_valid = 1'b0;
    check("phv_latency", m_phv_valid, 1'b1);
  endtask

  task automatic mod_accept(input logic [3:0] op, input logic [AW-1:0] a, input logic [SW-1:0] d);
    int budget = 200;
    s_mod_addr = a; s_mod_data = d; s_mod_opcode = op; s_mod_valid = 1'b1;
    #1;
    while (!s_mod_ready && budget > 0) begin
      @(negedge clk); #2; budget--;
    end
    if (budget == 0) check("mod_accept_timeout", 1'b0, 1'b1);
    step();
    s_mod_valid = 1'b0;
  endtask

  task automatic mod_resp(output logic [SW-1:0] bd);
    int budget = 200;
    m_mod_bready = 1'b1;
    while (!m_mod_bvalid && budget > 0) begin
      step(); budget--;
    end
    if (budget == 0) check("mod_resp_timeout", 1'b0, 1'b1);
    bd = m_mod_bdata;
    step();
    m_mod_bready = 1'b0;
    check("mod_single_resp", m_mod_bvalid, 1'b0);
  endtask

  task automatic mod_req(input logic [3:0] op, input logic [AW-1:0] a, input logic [SW-1:0] d,
                         input logic [SW-1:0] expd, input string name);
    logic [SW-1:0] bd;
    mod_accept(op, a, d);
    if (op != OP_CLEAR) check("mod_latency", m_mod_bvalid, 1'b1);
    mod_resp(bd);
    check(name, bd, expd);
  endtask

  task automatic mod_do(input logic [3:0] op, input logic [AW-1:0] a, input logic [SW-1:0] d,
                        input string name);
    logic [SW-1:0] e;
    e = mod_model(op, a, d);
    mod_req(op, a, d, e, name);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [PW:0] e;
    #3;
    if (!rst && m_phv_valid && m_phv_ready) begin
      if (exp_q.size() == 0) begin
        check("phv_unexpected", {m_phv_wrap, m_phv_info}, '0);
      end else begin
        e = exp_q.pop_front();
        check("phv_out", {m_phv_wrap, m_phv_info}, e);
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [PW:0]   ea;
    logic [PW:0]   eb;
    logic [PW-1:0] info;
    logic [95:0]   r;
    logic [SW-1:0] bd;
    int            cnt;
    int            stray;

    model_zero();
    vecs[0] = '{OP_WRITE, 4'd3,  32'h0000_1234, 32'h0000_1234};
    vecs[1] = '{OP_READ,  4'd3,  32'h0,         32'h0000_1234};
    vecs[2] = '{OP_WRITE, 4'd9,  32'hA5A5_0000, 32'hA5A5_0000};
    vecs[3] = '{OP_READ,  4'd9,  32'h0,         32'hA5A5_0000};
    vecs[4] = '{4'b0111,  4'd3,  32'h55,        32'h0};
    vecs[5] = '{OP_READ,  4'd3,  32'h0,         32'h0000_1234};
    vecs[6] = '{4'b0000,  4'd9,  32'h1,         32'h0};
    vecs[7] = '{4'b1111,  4'd9,  32'h2,         32'h0};
    vecs[8] = '{OP_READ,  4'd9,  32'h0,         32'hA5A5_0000};
    vecs[9] = '{OP_READ,  4'd12, 32'h0,         32'h0};

    // Reset values.
    repeat (3) step();
    check("rst_phv_valid", m_phv_valid, 1'b0);
    check("rst_phv_info", m_phv_info, '0);
    check("rst_phv_wrap", m_phv_wrap, 1'b0);
    check("rst_bvalid", m_mod_bvalid, 1'b0);
    check("rst_bdata", m_mod_bdata, '0);
    rst = 1'b0;
    step();
    check("idle_phv_ready", s_phv_ready, 1'b1);
    check("idle_mod_ready", s_mod_ready, 1'b1);

    // Management vector table.
    for (int i = 0; i < 10; i++) begin
      void'(mod_model(vecs[i].op, vecs[i].addr, vecs[i].data));
      mod_req(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].exp, "vec_bdata");
    end

    // Three back-to-back hits to flow 5 get 0,1,2; counter ends at 3.
    for (int i = 0; i < 3; i++) begin
      r = {$urandom, $urandom, $urandom};
      send_phv(r[PW-1:0], 1'b1, 4'd5, 1'b1, ea);
    end
    void'(mod_model(OP_READ, 4'd5, '0));
    mod_req(OP_READ, 4'd5, '0, 32'd3, "seq_after_3");

    // Wrap: all-ones stamps with wrap=1, then rolls to zero.
    mod_do(OP_WRITE, 4'd7, 32'hFFFF_FFFF, "write_ones");
    send_phv(72'h12_3456_789A_BCDE_F012, 1'b1, 4'd7, 1'b1, ea);
    check("wrap_first", ea[PW], 1'b1);
    send_phv(72'hFE_DCBA_9876_5432_10FE, 1'b1, 4'd7, 1'b1, ea);
    check("wrap_second", ea[PW], 1'b0);
    void'(mod_model(OP_READ, 4'd7, '0));
    mod_req(OP_READ, 4'd7, '0, 32'd1, "seq_after_wrap");

    // Pass-through: enable low, then miss; flow 2 stays untouched.
    send_phv(72'hAA_5555_AAAA_5555_AAAA, 1'b1, 4'd2, 1'b0, ea);
    send_phv(72'h0F_F0F0_0F0F_F0F0_0F0F, 1'b0, 4'd2, 1'b1, ea);
    void'(mod_model(OP_READ, 4'd2, '0));
    mod_req(OP_READ, 4'd2, '0, 32'd0, "passthru_state");
    void'(mod_model(OP_READ, 4'd5, '0));
    mod_req(OP_READ, 4'd5, '0, 32'd3, "passthru_other");

    // Back-pressure: output holds for 4 cycles, next PHV waits, no loss.
    ready_force = 1'b0;
    send_phv(72'h11_2233_4455_6677_8899, 1'b1, 4'd5, 1'b1, ea);
    s_phv_info = 72'h99_8877_6655_4433_2211; s_phv_hit = 1'b1;
    s_phv_addr = 4'd5; reliable_enable = 1'b1; s_phv_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_info", m_phv_info, ea[PW-1:0]);
      check("stall_ready", s_phv_ready, 1'b0);
      step();
    end
    ready_force = 1'b1;
    send_phv(72'h99_8877_6655_4433_2211, 1'b1, 4'd5, 1'b1, eb);
    repeat (3) step();
    check("stall_drained", exp_q.size(), 0);

    // CLEAR_ALL with a PHV draining during the sweep.
    mod_do(OP_WRITE, 4'd1, 32'h10, "pre_clear_w1");
    mod_do(OP_WRITE, 4'd14, 32'hDEAD_BEEF, "pre_clear_w14");
    ready_force = 1'b0;
    send_phv(72'h01_0203_0405_0607_0809, 1'b1, 4'd1, 1'b1, ea);
    mod_accept(OP_CLEAR, 4'd0, '0);
    model_zero();
    cnt = 0;
    while (!m_mod_bvalid && cnt < 40) begin
      check("clear_phv_blocked", s_phv_ready, 1'b0);
      if (cnt == 4) ready_force = 1'b1;
      cnt++;
      step();
    end
    check("clear_cycles", cnt, 16);
    check("clear_bdata", m_mod_bdata, '0);
    check("clear_drained", m_phv_valid, 1'b0);
    check("resp_phv_blocked", s_phv_ready, 1'b0);
    m_mod_bready = 1'b1;
    step();
    m_mod_bready = 1'b0;
    check("clear_one_resp", m_mod_bvalid, 1'b0);
    check("clear_back_idle", s_phv_ready, 1'b1);
    for (int a = 0; a < DEPTH; a++) mod_req(OP_READ, AW'(a), '0, 32'd0, "clear_read");

    // Reset in the middle of a sweep, with a stalled PHV output.
    mod_do(OP_WRITE, 4'd4, 32'h77, "pre_rst_w4");
    ready_force = 1'b0;
    send_phv(72'hC3_C3C3_C3C3_C3C3_C3C3, 1'b1, 4'd4, 1'b1, ea);
    mod_accept(OP_CLEAR, 4'd0, '0);
    repeat (8) step();
    rst = 1'b1;
    #1;
    check("midrst_phv_valid", m_phv_valid, 1'b0);
    check("midrst_phv_info", m_phv_info, '0);
    check("midrst_phv_wrap", m_phv_wrap, 1'b0);
    check("midrst_bvalid", m_mod_bvalid, 1'b0);
    check("midrst_bdata", m_mod_bdata, '0);
    exp_q.delete();
    model_zero();
    step();
    rst = 1'b0;
    ready_force = 1'b1;
    m_mod_bready = 1'b1;
    stray = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (m_mod_bvalid) stray++;
    end
    m_mod_bready = 1'b0;
    check("midrst_no_resp", stray, 0);
    check("midrst_idle", s_mod_ready, 1'b1);
    for (int a = 0; a < DEPTH; a++) mod_do(OP_READ, AW'(a), '0, "midrst_read");

    // Randomized traffic with random output back-pressure.
    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 8) begin
        r = {$urandom, $urandom, $urandom};
        info = r[PW-1:0];
        send_phv(info, ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) != 0), ea);
      end else begin
        case ($urandom_range(0, 2))
          0: mod_do(OP_READ, AW'($urandom_range(0, 3)), '0, "rnd_read");
          1: mod_do(OP_WRITE, AW'($urandom_range(0, 3)),
                    32'hFFFF_FFFF - SW'($urandom_range(0, 2)), "rnd_write");
          default: mod_do(4'($urandom_range(3, 12)), AW'($urandom_range(0, 3)),
                          $urandom, "rnd_badop");
        endcase
      end
    end
    rnd_bp = 1'b0;
    ready_force = 1'b1;
    repeat (4) step();
    check("final_drained", exp_q.size(), 0);
    for (int a = 0; a < DEPTH; a++) mod_do(OP_READ, AW'(a), '0, "final_read");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
